alpha_sched: RTL
================

# alpha_sched

Descent scheduler for the alpha (LLR) layer storage of the SCAN polar decoder (N=1024, P=256). On a start command it walks the storage from a start layer down to an end layer. For each layer step it issues the read, PE-wait and write cycles needed to compute the child LLRs: f or g on the first step, f on every later step. It drives the layer, count and enable inputs of the alpha storage and the f/g select of the PE array, and reports busy/done to the top-level decode FSM.

## Interface
- N, 1024, code length; layers numbered 1..log2(N)
- P, 256, PE count (LLRs produced per pass)
- PE_LAT, 1, registered PE stages between storage output and write data (0..3)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle command pulse
- start_layer  in  5  layer read on the first step (2..10)
- end_layer  in  5  last layer written (1..start_layer-1)
- op_g  in  1  first step computes g (1) or f (0)
- busy  out  1  high while a descent is in progress
- done  out  1  one-cycle pulse when the descent completes
- layer_r  out  5  storage read layer
- cntb  out  4  storage read pass index (0-based)
- r_en  out  1  storage read enable
- layer_w  out  5  storage write layer
- cnta  out  5  storage write pass index (0-based)
- w_en  out  1  storage write enable
- pe_g  out  1  PE select: 1=g, 0=f

## Operation
- States: IDLE, RD, WT, WR, FIN.
- IDLE: accept start only if 2 ≤ start_layer ≤ log2(N) and 1 ≤ end_layer < start_layer. An invalid or out-of-IDLE start is ignored: no busy, no done.
- On accept, latch end_layer and op_g, set cur=start_layer and pass=0, then go to RD.
- Passes per step reading layer k: npass(k) = 2^(k-1)/P if 2^(k-1) > P, else 1. For the defaults: k=10 gives 2, every other k gives 1.
- RD (1 cycle): r_en=1, layer_r=cur, cntb=pass. Go to WT if PE_LAT>0, else WR.
- WT (PE_LAT cycles): all enables low.
- WR (1 cycle): w_en=1, layer_w=cur-1, cnta=pass.
  - If pass<npass(cur)-1: pass++, go to RD.
  - Else if cur-1 > end_layer: cur--, pass=0, go to RD.
  - Else go to FIN.
- FIN (1 cycle): done=1, busy=0, then go to IDLE.
- pe_g = op_g during the RD/WT/WR cycles of the first step (cur==start_layer); 0 otherwise.
- Outside RD: r_en=0, layer_r=0, cntb=0. Outside WR: w_en=0, layer_w=0, cnta=0.
- The storage zeroes its outputs when r_en is low. The PE array captures in the cycle after RD.
- A step may read layer cur-1 in the cycle after it is written; storage write-then-read ordering guarantees this is safe.

## Timing
- Reset (async assert, any state): IDLE immediately. All outputs are 0 and all counters cleared. Release is synchronous to clk.
- start accepted at cycle t: busy=1 from t+1. The first RD occurs at t+1.
- Pass length: 2+PE_LAT cycles (RD at c, WR at c+1+PE_LAT, next RD at c+2+PE_LAT).
- Total passes T = sum of npass(k) for k = end_layer+1 .. start_layer.
- Last WR occurs at t+T·(2+PE_LAT). done pulses at t+T·(2+PE_LAT)+1, with busy=0 in that cycle.
- Back-to-back: a start in the FIN cycle is ignored. A start one cycle after FIN is accepted.
- r_en and w_en are never high in the same cycle.

## Structure
- Shared package alpha_pkg holds:
  - constants LOGN=10, LW=5, CBW=4, CAW=5;
  - the state enum;
  - function npass(k, P).
- Sub-module lat_timer: a down-counter loaded with PE_LAT on RD exit, asserting expire on its last WT cycle. Everything else stays inline in one FSM.

## Test plan
- start_layer=10, end_layer=1, op_g=0, PE_LAT=1 -> 10 passes:
  - RD at t+1 and t+4 with layer_r=10, cntb=0/1;
  - WR at t+3 and t+6 with layer_w=9, cnta=0/1;
  - then layers 9→8 … 2→1, one pass each;
  - done at t+31; pe_g stays 0 throughout.
- start_layer=5, end_layer=3, op_g=1, PE_LAT=0:
  - RD5 at t+1, WR4 at t+2 with pe_g=1;
  - RD4 at t+3, WR3 at t+4 with pe_g=0;
  - done at t+5.
- Invalid commands -> no busy and no done:
  - start_layer=1;
  - end_layer=start_layer=6;
  - start_layer=11.
- start pulsed at busy+3 during a 10→1 descent -> ignored; schedule and done timing are identical to the first scenario.
- rst asserted mid-WT of layer-9 step -> all outputs 0 within the same cycle, no done. After release, a new start at 4→1 completes normally.
- PE_LAT=3, start_layer=10, end_layer=8 -> 3 passes of 5 cycles each. No overlap of r_en/w_en; done at t+16.

Source files
------------

// File: rtl/alpha_pkg.sv
// Shared constants, state encoding and pass-count helper for the alpha-layer
// descent scheduler of the SCAN polar decoder.
package alpha_pkg;

    localparam int LOGN = 10;
    localparam int LW   = 5;
    localparam int CBW  = 4;
    localparam int CAW  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WT,
        ST_WR,
        ST_FIN
    } state_t;

    // A layer-k read yields 2^(k-1) child LLRs, produced P at a time.
    function automatic int npass(input int k, input int p);
        int half;
        half = 1 << (k - 1);
        if (half > p) begin
            return half / p;
        end
        return 1;
    endfunction

endpackage

// File: rtl/alpha_sched_lat_timer.sv
// PE latency timer: counts out the wait cycles between a storage read and the
// matching write, flagging the last wait cycle.
module lat_timer
    import alpha_pkg::*;
#(
    parameter int PE_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 2'(PE_LAT);
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == 2'd1);

endmodule

// File: rtl/alpha_sched.sv
// Descent scheduler for the alpha (LLR) storage: walks from a start layer down
// to an end layer, issuing read / PE-wait / write cycles for each pass.
module alpha_sched
    import alpha_pkg::*;
#(
    parameter int N      = 1024,
    parameter int P      = 256,
    parameter int PE_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LW-1:0]  start_layer,
    input  logic [LW-1:0]  end_layer,
    input  logic           op_g,
    output logic           busy,
    output logic           done,
    output logic [LW-1:0]  layer_r,
    output logic [CBW-1:0] cntb,
    output logic           r_en,
    output logic [LW-1:0]  layer_w,
    output logic [CAW-1:0] cnta,
    output logic           w_en,
    output logic           pe_g
);

    localparam int MAX_LAYER = $clog2(N);

    state_t         state_q, state_d;
    logic [LW-1:0]  cur_q, cur_d;
    logic [CBW-1:0] pass_q, pass_d;
    logic [LW-1:0]  end_q, end_d;
    logic           op_g_q, op_g_d;
    logic           first_q, first_d;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [LW-1:0]  layer_r_q, layer_r_d;
    logic [CBW-1:0] cntb_q, cntb_d;
    logic           r_en_q, r_en_d;
    logic [LW-1:0]  layer_w_q, layer_w_d;
    logic [CAW-1:0] cnta_q, cnta_d;
    logic           w_en_q, w_en_d;
    logic           pe_g_q, pe_g_d;

    logic start_ok;
    logic last_pass;
    logic more_layers;
    logic lat_expire;
    logic lat_load;

    assign lat_load = (state_q == ST_RD);

    lat_timer #(
        .PE_LAT (PE_LAT)
    ) u_lat_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (lat_load),
        .expire (lat_expire)
    );

    assign start_ok = (int'(start_layer) >= 2) && (int'(start_layer) <= MAX_LAYER)
                   && (int'(end_layer) >= 1) && (end_layer < start_layer);

    assign last_pass   = int'(pass_q) >= (npass(int'(cur_q), P) - 1);
    assign more_layers = (cur_q - LW'(1)) > end_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pass_d  = pass_q;
        end_d   = end_q;
        op_g_d  = op_g_q;
        first_d = first_q;

        case (state_q)
            ST_IDLE: begin
                if (start && start_ok) begin
                    cur_d   = start_layer;
                    pass_d  = '0;
                    end_d   = end_layer;
                    op_g_d  = op_g;
                    first_d = 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = (PE_LAT > 0) ? ST_WT : ST_WR;
            end
            ST_WT: begin
                if (lat_expire) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (!last_pass) begin
                    pass_d  = pass_q + CBW'(1);
                    state_d = ST_RD;
                end else if (more_layers) begin
                    cur_d   = cur_q - LW'(1);
                    pass_d  = '0;
                    first_d = 1'b0;
                    state_d = ST_RD;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        busy_d    = (state_d == ST_RD) || (state_d == ST_WT) || (state_d == ST_WR);
        done_d    = (state_d == ST_FIN);
        r_en_d    = (state_d == ST_RD);
        layer_r_d = r_en_d ? cur_d : '0;
        cntb_d    = r_en_d ? pass_d : '0;
        w_en_d    = (state_d == ST_WR);
        layer_w_d = w_en_d ? (cur_d - LW'(1)) : '0;
        cnta_d    = w_en_d ? CAW'(pass_d) : '0;
        pe_g_d    = busy_d && first_d && op_g_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            pass_q    <= '0;
            end_q     <= '0;
            op_g_q    <= 1'b0;
            first_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            layer_r_q <= '0;
            cntb_q    <= '0;
            r_en_q    <= 1'b0;
            layer_w_q <= '0;
            cnta_q    <= '0;
            w_en_q    <= 1'b0;
            pe_g_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            pass_q    <= pass_d;
            end_q     <= end_d;
            op_g_q    <= op_g_d;
            first_q   <= first_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            layer_r_q <= layer_r_d;
            cntb_q    <= cntb_d;
            r_en_q    <= r_en_d;
            layer_w_q <= layer_w_d;
            cnta_q    <= cnta_d;
            w_en_q    <= w_en_d;
            pe_g_q    <= pe_g_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign layer_r = layer_r_q;
    assign cntb    = cntb_q;
    assign r_en    = r_en_q;
    assign layer_w = layer_w_q;
    assign cnta    = cnta_q;
    assign w_en    = w_en_q;
    assign pe_g    = pe_g_q;

endmodule
